// File: rtl/fb_pkg.sv
// fb_pkg: framebuffer geometry, coordinate/error types and line drawer states
// shared by the line drawer and its Bresenham step.
package fb_pkg;
    localparam int H_DIM = 800;
    localparam int V_DIM = 600;
    typedef logic [10:0]        xcoord_t;
    typedef logic [9:0]         ycoord_t;
    typedef logic signed [11:0] delta_t;
    typedef logic signed [12:0] err_t;
    typedef enum logic [2:0] {IDLE, INIT, DRAW, CLEAR, FIN} ld_state_t;
endpackage

// File: rtl/line_step.sv
// line_step: one combinational Bresenham step from the current point and error;
// both axis updates use the same doubled error and apply together.
module line_step
    import fb_pkg::*;
(
    input  err_t    err,
    input  delta_t  dx,
    input  delta_t  dy,
    input  logic    sx_neg,
    input  logic    sy_neg,
    input  xcoord_t cx,
    input  ycoord_t cy,
    output err_t    err_nxt,
    output xcoord_t cx_nxt,
    output ycoord_t cy_nxt
);
    logic signed [13:0] e2;
    logic               step_x;
    logic               step_y;
    always_comb begin
        e2      = {err, 1'b0};
        step_x  = e2 >= $signed({{2{dy[11]}}, dy});
        step_y  = e2 <= $signed({{2{dx[11]}}, dx});
        err_nxt = err + (step_x ? $signed({dy[11], dy}) : 13'sd0)
                      + (step_y ? $signed({dx[11], dx}) : 13'sd0);
        cx_nxt  = step_x ? (sx_neg ? cx - 11'd1 : cx + 11'd1) : cx;
        cy_nxt  = step_y ? (sy_neg ? cy - 10'd1 : cy + 10'd1) : cy;
    end
endmodule

// File: rtl/line_drawer.sv
// line_drawer: command-driven pixel generator (Bresenham line or full-screen clear)
// issuing one registered framebuffer write per enabled cycle.
module line_drawer
    import fb_pkg::*;
#(
    parameter int h_dim = H_DIM,
    parameter int v_dim = V_DIM
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_line,
    input  logic        start_clear,
    input  logic [10:0] x0,
    input  logic [9:0]  y0,
    input  logic [10:0] x1,
    input  logic [9:0]  y1,
    input  logic        color,
    input  logic        draw_en,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic        pixel_color,
    output logic        pixel_write,
    output logic        busy,
    output logic        done
);
    localparam xcoord_t X_LAST = xcoord_t'(h_dim - 1);
    localparam ycoord_t Y_LAST = ycoord_t'(v_dim - 1);

    ld_state_t state_q, state_d;
    xcoord_t   cx_q, cx_d, ex_q, ex_d, x_q, x_d, cx_step, adx;
    ycoord_t   cy_q, cy_d, ey_q, ey_d, y_q, y_d, cy_step, ady;
    delta_t    dx_q, dx_d, dy_q, dy_d;
    err_t      err_q, err_d, err_step;
    logic      sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d, color_q, color_d;
    logic      pc_q, pc_d, pw_q, pw_d, busy_q, busy_d, done_q, done_d;
    logic      at_end, in_range;

    assign adx      = ex_q >= cx_q ? ex_q - cx_q : cx_q - ex_q;
    assign ady      = ey_q >= cy_q ? ey_q - cy_q : cy_q - ey_q;
    assign at_end   = cx_q == ex_q && cy_q == ey_q;
    assign in_range = cx_q <= X_LAST && cy_q <= Y_LAST;

    line_step u_step (
        .err    (err_q),
        .dx     (dx_q),
        .dy     (dy_q),
        .sx_neg (sx_neg_q),
        .sy_neg (sy_neg_q),
        .cx     (cx_q),
        .cy     (cy_q),
        .err_nxt(err_step),
        .cx_nxt (cx_step),
        .cy_nxt (cy_step)
    );

    always_comb begin
        state_d  = state_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        ex_d     = ex_q;
        ey_d     = ey_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        err_d    = err_q;
        sx_neg_d = sx_neg_q;
        sy_neg_d = sy_neg_q;
        color_d  = color_q;
        x_d      = x_q;
        y_d      = y_q;
        pc_d     = pc_q;
        pw_d     = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_clear) begin
                    color_d = color;
                    cx_d    = '0;
                    cy_d    = '0;
                    busy_d  = 1'b1;
                    state_d = CLEAR;
                end else if (start_line) begin
                    color_d = color;
                    cx_d    = x0;
                    cy_d    = y0;
                    ex_d    = x1;
                    ey_d    = y1;
                    busy_d  = 1'b1;
                    state_d = INIT;
                end
            end
            INIT: begin
                dx_d     = {1'b0, adx};
                dy_d     = 12'd0 - {2'b0, ady};
                err_d    = {dx_d[11], dx_d} + {dy_d[11], dy_d};
                sx_neg_d = !(cx_q < ex_q);
                sy_neg_d = !(cy_q < ey_q);
                state_d  = DRAW;
            end
            DRAW: begin
                if (draw_en) begin
                    x_d  = cx_q;
                    y_d  = cy_q;
                    pc_d = color_q;
                    // off-screen points still consume a step so the walk stays exact
                    pw_d = in_range;
                    if (at_end) begin
                        state_d = FIN;
                    end else begin
                        cx_d  = cx_step;
                        cy_d  = cy_step;
                        err_d = err_step;
                    end
                end
            end
            CLEAR: begin
                if (draw_en) begin
                    x_d  = cx_q;
                    y_d  = cy_q;
                    pc_d = color_q;
                    pw_d = 1'b1;
                    cx_d = cx_q == X_LAST ? '0 : cx_q + 11'd1;
                    cy_d = cx_q == X_LAST ? cy_q + 10'd1 : cy_q;
                    if (cx_q == X_LAST && cy_q == Y_LAST) state_d = FIN;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cx_q     <= '0;
            cy_q     <= '0;
            ex_q     <= '0;
            ey_q     <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            err_q    <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
            color_q  <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            pc_q     <= 1'b0;
            pw_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            ex_q     <= ex_d;
            ey_q     <= ey_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            err_q    <= err_d;
            sx_neg_q <= sx_neg_d;
            sy_neg_q <= sy_neg_d;
            color_q  <= color_d;
            x_q      <= x_d;
            y_q      <= y_d;
            pc_q     <= pc_d;
            pw_q     <= pw_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign pixel_color = pc_q;
    assign pixel_write = pw_q;
    assign busy        = busy_q;
    assign done        = done_q;
endmodule
